// File: rtl/acc_readout_tx.sv
// Serial readout transmitter: captures the accumulator value on request and sends
// start, 8 data bits LSB-first, even parity and stop, each held CLKS_PER_BIT cycles.
module acc_readout_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] acc_data,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic             busy,
  output logic             txd,
  output logic             done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             rd_ack_q, rd_ack_d;
  logic             done_q, done_d;
  logic             bit_end;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    bit_end  = (cnt_q == CntMax);

    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (rd_req) begin
          state_d  = StStart;
          shift_d  = acc_data;
          parity_d = ^acc_data;
          cnt_d    = '0;
          idx_d    = '0;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == IdxMax) begin
            state_d = StParity;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          idx_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    busy_d   = (state_d != StIdle);
    rd_ack_d = (state_q == StIdle) && (state_d == StStart);
    done_d   = (state_q == StStop) && (state_d == StIdle);
    unique case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
      StParity: txd_d = parity_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      rd_ack_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      rd_ack_q <= rd_ack_d;
      done_q   <= done_d;
    end
  end

  assign txd    = txd_q;
  assign busy   = busy_q;
  assign rd_ack = rd_ack_q;
  assign done   = done_q;

endmodule

// File: tb/tb_acc_readout_tx.sv
// Bench for acc_readout_tx: two instances (C=4 and C=1) share stimulus; a frame-level
// reference model queues expected per-cycle outputs and a monitor compares them.
module tb_acc_readout_tx;

  localparam int unsigned C0 = 4;
  localparam int unsigned C1 = 1;

  logic       clk;
  logic       reset;
  logic       rd_req;
  logic [7:0] acc_data;
  logic       rd_ack0, busy0, txd0, done0;
  logic       rd_ack1, busy1, txd1, done1;

  acc_readout_tx #(.WIDTH(8), .CLKS_PER_BIT(C0)) u_dut0 (
    .clk      (clk),
    .reset    (reset),
    .acc_data (acc_data),
    .rd_req   (rd_req),
    .rd_ack   (rd_ack0),
    .busy     (busy0),
    .txd      (txd0),
    .done     (done0)
  );

  acc_readout_tx #(.WIDTH(8), .CLKS_PER_BIT(C1)) u_dut1 (
    .clk      (clk),
    .reset    (reset),
    .acc_data (acc_data),
    .rd_req   (rd_req),
    .rd_ack   (rd_ack1),
    .busy     (busy1),
    .txd      (txd1),
    .done     (done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks;
  int          failures;
  int          cycle;
  logic [3:0]  exp0[$];
  logic [3:0]  exp1[$];
  logic [3:0]  e0, e1, p0, p1;

  // Model state per instance: in-frame flag, cycles into the frame, frame bits LSB-first.
  bit          m_in[2];
  int          m_t[2];
  logic [10:0] m_bits[2];

  // Expected tuple {txd, busy, rd_ack, done} for the cycle after the current edge.
  task automatic model_step(input int i, output logic [3:0] e);
    int c;
    c = (i == 0) ? int'(C0) : int'(C1);
    if (reset) begin
      m_in[i] = 1'b0;
      e = 4'b1000;
    end else if (!m_in[i]) begin
      if (rd_req) begin
        m_in[i]   = 1'b1;
        m_t[i]    = 1;
        m_bits[i] = {1'b1, ^acc_data, acc_data, 1'b0};
        e = 4'b0110;
      end else begin
        e = 4'b1000;
      end
    end else begin
      m_t[i] = m_t[i] + 1;
      if (m_t[i] > 11 * c) begin
        m_in[i] = 1'b0;
        e = 4'b1001;
      end else begin
        e = {m_bits[i][(m_t[i] - 1) / c], 3'b100};
      end
    end
  endtask

  always @(posedge clk) begin
    cycle <= cycle + 1;
    model_step(0, e0);
    exp0.push_back(e0);
    model_step(1, e1);
    exp1.push_back(e1);
  end

  task automatic check(input int inst, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL out_c%0d cycle=%0d got {txd,busy,ack,done}=%b expected=%b",
               (inst == 0) ? C0 : C1, cycle, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp0.size() == 0 || exp1.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty cycle=%0d got sizes %0d/%0d expected nonzero",
               cycle, exp0.size(), exp1.size());
    end else begin
      p0 = exp0.pop_front();
      p1 = exp1.pop_front();
      check(0, {txd0, busy0, rd_ack0, done0}, p0);
      check(1, {txd1, busy1, rd_ack1, done1}, p1);
    end
  end

  task automatic drive(input logic r, input logic q, input logic [7:0] d);
    reset    = r;
    rd_req   = q;
    acc_data = d;
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cycle    = 0;
    // Reset held with a pending request: nothing may start.
    reset    = 1'b1;
    rd_req   = 1'b1;
    acc_data = 8'hA5;
    @(negedge clk);
    drive(1'b1, 1'b1, 8'hA5);
    drive(1'b1, 1'b1, 8'hA5);
    repeat (4) drive(1'b0, 1'b0, 8'h00);

    // Single frame of 0xA5.
    drive(1'b0, 1'b1, 8'hA5);
    repeat (50) drive(1'b0, 1'b0, 8'h00);

    // 0x07 with acc_data changing mid-frame.
    drive(1'b0, 1'b1, 8'h07);
    drive(1'b0, 1'b0, 8'h07);
    repeat (50) drive(1'b0, 1'b0, 8'hFF);

    // Requests while busy are ignored.
    drive(1'b0, 1'b1, 8'h5A);
    for (int k = 1; k < 50; k++) drive(1'b0, (k == 9) || (k == 29), 8'h33);

    // Held request gives back-to-back frames.
    repeat (100) drive(1'b0, 1'b1, 8'hC3);
    repeat (50) drive(1'b0, 1'b0, 8'h00);

    // Reset during the data phase, then a fresh frame.
    drive(1'b0, 1'b1, 8'h96);
    repeat (18) drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    repeat (50) drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h3C);
    repeat (50) drive(1'b0, 1'b0, 8'h00);

    for (int k = 0; k < 1500; k++) begin
      drive($urandom_range(199) == 0, $urandom_range(7) == 0, 8'($urandom));
    end
    repeat (50) drive(1'b0, 1'b0, 8'h00);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
